// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and its datapath:
// opcode/funct values, FSM state codes, datapath select encodings and
// the decoded instruction class record.
package mc_ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct field values for op = 0
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // FSM state codes; 5..7 are unused and recover to FETCH
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Immediate extension select
  localparam logic [1:0] EOP_SEXT     = 2'b00;
  localparam logic [1:0] EOP_ZEXT     = 2'b01;
  localparam logic [1:0] EOP_HIGH     = 2'b10;
  localparam logic [1:0] EOP_SEXT_SL2 = 2'b11;

  // ALU operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  // Next-PC select
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  // Register-file write-data select
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  // Register-file destination select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // One-hot instruction class; exactly one field is set for any op/funct
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic ill;
  } iclass_t;

  // R-type ALU instructions write rd rather than rt
  function automatic logic is_rtype_alu(input iclass_t c);
    return c.addu | c.subu;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle.
// Handshake: im_ready / dm_ready are completion flags from the memories.
// A request (FETCH state, or DMWr/DMRd) is held unchanged every cycle until
// the matching ready is sampled high on a rising edge; that edge completes
// the transfer and the request is dropped or advanced on the next cycle.
interface mc_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        im_ready;
  logic        dm_ready;
  logic        PCWr;
  logic        IRWr;
  logic        RFWr;
  logic        DMWr;
  logic        DMRd;
  logic [1:0]  EOp;
  logic [2:0]  ALUOp;
  logic        ALUSrcB;
  logic [1:0]  RegDst;
  logic [1:0]  WDSel;
  logic [1:0]  NPCOp;
  logic [2:0]  state;
  logic        ill;
  logic [31:0] icnt;

  // Controller side
  modport master (
    input  op, funct, zero, im_ready, dm_ready,
    output PCWr, IRWr, RFWr, DMWr, DMRd, EOp, ALUOp, ALUSrcB,
           RegDst, WDSel, NPCOp, state, ill, icnt
  );

  // Datapath / memory side
  modport slave (
    output op, funct, zero, im_ready, dm_ready,
    input  PCWr, IRWr, RFWr, DMWr, DMRd, EOp, ALUOp, ALUSrcB,
           RegDst, WDSel, NPCOp, state, ill, icnt
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR op/funct -> one-hot class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  // Classify the instruction; anything unrecognised is illegal
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls.ill  = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB FSM,
// strobe and select generation, retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  mc_ctrl_if.master   bus
);

  state_e      state_q, state_d;
  logic [31:0] icnt_q, icnt_d;
  iclass_t     cls;

  logic       pc_wr, ir_wr, rf_wr, dm_wr, dm_rd, ill, retire;
  logic       alu_src_b;
  logic [1:0] eop, reg_dst, wd_sel, npc_op;
  logic [2:0] alu_op;

  mc_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
    end
  end

  // Next state, strobes and selects; retire marks a legal instruction's
  // final cycle, i.e. the transition back to FETCH that counts
  always_comb begin
    state_d   = state_q;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    rf_wr     = 1'b0;
    dm_wr     = 1'b0;
    dm_rd     = 1'b0;
    ill       = 1'b0;
    retire    = 1'b0;
    alu_src_b = 1'b0;
    eop       = EOP_SEXT;
    alu_op    = ALU_ADD;
    reg_dst   = RD_RT;
    wd_sel    = WD_ALU;
    npc_op    = NPC_PC4;
    case (state_q)
      ST_FETCH: begin
        if (bus.im_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          npc_op  = NPC_PC4;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (cls.ill) begin
          ill = 1'b1;
        end else if (cls.j) begin
          pc_wr  = 1'b1;
          npc_op = NPC_JUMP;
          retire = 1'b1;
        end else if (cls.jal) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_JUMP;
          rf_wr   = 1'b1;
          reg_dst = RD_RA;
          wd_sel  = WD_PC4;
          retire  = 1'b1;
        end else if (cls.jr) begin
          pc_wr  = 1'b1;
          npc_op = NPC_JR;
          retire = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (cls.addu) begin
          alu_op  = ALU_ADD;
          state_d = ST_WB;
        end else if (cls.subu) begin
          alu_op  = ALU_SUB;
          state_d = ST_WB;
        end else if (cls.ori) begin
          alu_op    = ALU_OR;
          alu_src_b = 1'b1;
          eop       = EOP_ZEXT;
          state_d   = ST_WB;
        end else if (cls.lui) begin
          alu_op    = ALU_PASSB;
          alu_src_b = 1'b1;
          eop       = EOP_HIGH;
          state_d   = ST_WB;
        end else if (cls.lw || cls.sw) begin
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          eop       = EOP_SEXT;
          state_d   = ST_MEM;
        end else if (cls.beq) begin
          alu_op    = ALU_SUB;
          alu_src_b = 1'b0;
          eop       = EOP_SEXT_SL2;
          npc_op    = NPC_BRANCH;
          pc_wr     = bus.zero;
          retire    = 1'b1;
        end
      end
      ST_MEM: begin
        if (cls.sw) begin
          dm_wr = 1'b1;
          if (bus.dm_ready) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end else if (cls.lw) begin
          dm_rd = 1'b1;
          if (bus.dm_ready) state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        rf_wr   = 1'b1;
        reg_dst = is_rtype_alu(cls) ? RD_RD : RD_RT;
        wd_sel  = cls.lw ? WD_MEM : WD_ALU;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    icnt_d = retire ? icnt_q + 32'd1 : icnt_q;
  end

  // Outputs are forced quiet while reset is held, independent of the
  // memory handshakes (state already reads FETCH during reset)
  assign bus.PCWr    = reset_n & pc_wr;
  assign bus.IRWr    = reset_n & ir_wr;
  assign bus.RFWr    = reset_n & rf_wr;
  assign bus.DMWr    = reset_n & dm_wr;
  assign bus.DMRd    = reset_n & dm_rd;
  assign bus.ill     = reset_n & ill;
  assign bus.ALUSrcB = reset_n & alu_src_b;
  assign bus.EOp     = reset_n ? eop     : 2'b00;
  assign bus.ALUOp   = reset_n ? alu_op  : 3'b000;
  assign bus.RegDst  = reset_n ? reg_dst : 2'b00;
  assign bus.WDSel   = reset_n ? wd_sel  : 2'b00;
  assign bus.NPCOp   = reset_n ? npc_op  : 2'b00;
  assign bus.state   = state_q;
  assign bus.icnt    = icnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: every cycle the driver applies inputs and
// pushes the hand-computed output vector; a monitor on the falling edge
// pops and compares against the live DUT outputs.
module tb_mc_ctrl;
  localparam int W = 53;

  logic clk;
  logic reset_n;
  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_cyc    = 0;
  logic [31:0]  exp_icnt = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector without icnt, field order matches the monitor
  function automatic logic [20:0] mk(input int st, pc, ir, rf, dw, dr,
                                     eop, alu, sb, rd, wd, npc, il);
    return {st[2:0], pc[0], ir[0], rf[0], dw[0], dr[0], eop[1:0],
            alu[2:0], sb[0], rd[1:0], wd[1:0], npc[1:0], il[0]};
  endfunction

  // Driver: one clock cycle of inputs plus its expected outputs
  task automatic cyc(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic imr, input logic dmr,
                     input logic [20:0] e);
    @(posedge clk);
    #1;
    reset_n      = rst;
    bus.op       = o;
    bus.funct    = f;
    bus.zero     = z;
    bus.im_ready = imr;
    bus.dm_ready = dmr;
    exp_q.push_back({e, exp_icnt});
  endtask

  task automatic fetch(input logic [5:0] o, input logic [5:0] f);
    cyc(1'b1, o, f, 1'b0, 1'b1, 1'b1, mk(0,1,1,0,0,0,0,0,0,0,0,0,0));
  endtask

  task automatic decode_quiet(input logic [5:0] o, input logic [5:0] f);
    cyc(1'b1, o, f, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.state, bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr, bus.DMRd,
           bus.EOp, bus.ALUOp, bus.ALUSrcB, bus.RegDst, bus.WDSel,
           bus.NPCOp, bus.ill, bus.icnt};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: actual=%h expected=%h (state act=%0d exp=%0d, icnt act=%0d exp=%0d)",
                 n_cyc, a, e, a[52:50], e[52:50], a[31:0], e[31:0]);
      end
      n_cyc++;
    end
  end

  // Stimulus
  initial begin
    reset_n      = 1'b0;
    bus.op       = 6'h00;
    bus.funct    = 6'h00;
    bus.zero     = 1'b0;
    bus.im_ready = 1'b1;
    bus.dm_ready = 1'b1;

    // Reset held with both readys high: everything quiet
    cyc(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

    // ori: 0,1,2,4
    fetch(6'h0D, 6'h00);
    decode_quiet(6'h0D, 6'h00);
    cyc(1'b1, 6'h0D, 6'h00, 1'b0, 1'b1, 1'b1, mk(2,0,0,0,0,0,1,2,1,0,0,0,0));
    cyc(1'b1, 6'h0D, 6'h00, 1'b0, 1'b1, 1'b1, mk(4,0,0,1,0,0,0,0,0,0,0,0,0));
    exp_icnt = 1;

    // beq taken then not taken
    fetch(6'h04, 6'h00);
    decode_quiet(6'h04, 6'h00);
    cyc(1'b1, 6'h04, 6'h00, 1'b1, 1'b1, 1'b1, mk(2,1,0,0,0,0,3,1,0,0,0,1,0));
    exp_icnt = 2;
    fetch(6'h04, 6'h00);
    decode_quiet(6'h04, 6'h00);
    cyc(1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 1'b1, mk(2,0,0,0,0,0,3,1,0,0,0,1,0));
    exp_icnt = 3;

    // lw with three data-memory wait cycles
    fetch(6'h23, 6'h00);
    decode_quiet(6'h23, 6'h00);
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, mk(2,0,0,0,0,0,0,0,1,0,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, mk(3,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, mk(3,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, mk(4,0,0,1,0,0,0,0,0,0,1,0,0));
    exp_icnt = 4;

    // Illegal opcode: ill pulse, no count
    fetch(6'h3F, 6'h00);
    cyc(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0,1));

    // jal
    fetch(6'h03, 6'h00);
    cyc(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, 1'b1, mk(1,1,0,1,0,0,0,0,0,2,2,2,0));
    exp_icnt = 5;

    // addu, subu
    fetch(6'h00, 6'h21);
    decode_quiet(6'h00, 6'h21);
    cyc(1'b1, 6'h00, 6'h21, 1'b0, 1'b1, 1'b1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1'b1, 6'h00, 6'h21, 1'b0, 1'b1, 1'b1, mk(4,0,0,1,0,0,0,0,0,1,0,0,0));
    exp_icnt = 6;
    fetch(6'h00, 6'h23);
    decode_quiet(6'h00, 6'h23);
    cyc(1'b1, 6'h00, 6'h23, 1'b0, 1'b1, 1'b1, mk(2,0,0,0,0,0,0,1,0,0,0,0,0));
    cyc(1'b1, 6'h00, 6'h23, 1'b0, 1'b1, 1'b1, mk(4,0,0,1,0,0,0,0,0,1,0,0,0));
    exp_icnt = 7;

    // Illegal R-type funct
    fetch(6'h00, 6'h20);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0,1));

    // j, jr
    fetch(6'h02, 6'h00);
    cyc(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, mk(1,1,0,0,0,0,0,0,0,0,0,2,0));
    exp_icnt = 8;
    fetch(6'h00, 6'h08);
    cyc(1'b1, 6'h00, 6'h08, 1'b0, 1'b1, 1'b1, mk(1,1,0,0,0,0,0,0,0,0,0,3,0));
    exp_icnt = 9;

    // lui
    fetch(6'h0F, 6'h00);
    decode_quiet(6'h0F, 6'h00);
    cyc(1'b1, 6'h0F, 6'h00, 1'b0, 1'b1, 1'b1, mk(2,0,0,0,0,0,2,3,1,0,0,0,0));
    cyc(1'b1, 6'h0F, 6'h00, 1'b0, 1'b1, 1'b1, mk(4,0,0,1,0,0,0,0,0,0,0,0,0));
    exp_icnt = 10;

    // FETCH holds while im_ready is low
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

    // sw, zero wait states
    fetch(6'h2B, 6'h00);
    decode_quiet(6'h2B, 6'h00);
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, mk(2,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, mk(3,0,0,0,1,0,0,0,0,0,0,0,0));
    exp_icnt = 11;

    // sw interrupted by reset while DMWr is waiting
    fetch(6'h2B, 6'h00);
    decode_quiet(6'h2B, 6'h00);
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, mk(2,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, mk(3,0,0,0,1,0,0,0,0,0,0,0,0));
    exp_icnt = 0;
    cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    fetch(6'h02, 6'h00);
    cyc(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, mk(1,1,0,0,0,0,0,0,0,0,0,2,0));
    exp_icnt = 1;
    cyc(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual=%0d entries left, expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
